fetch_stall_pipe: RTL and testbench

- Fetch-side consumer of the load-use hazard signals (PC stall, IF/ID stall, nop/bubble control) and of the branch-flush request.
- Owns the PC register, the IF/ID pipeline register and the control field of the ID/EX register.
- Applies hold, flush and bubble semantics cycle-exactly.
- Keeps stall/bubble performance counters and a stall watchdog.

---
 rtl/fetch_stall_pipe.sv | 107 ++++++++++
 tb/tb_fetch_stall_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_pipe.sv
// Fetch-side hazard consumer: PC register, IF/ID register and ID/EX control with
// hold/flush/bubble semantics, saturating stall/bubble counters and a stall watchdog.
// Optional stall-agreement checker is built when FETCH_STALL_CHECK_EN is defined.
module fetch_stall_pipe #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              CTRL_W    = 10,
    parameter int              CNT_W     = 16,
    parameter int              MAX_STALL = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_stall_i,
    input  logic              ifid_stall_i,
    input  logic              nop_ctrl_i,
    input  logic              branch_taken_i,
    input  logic [PC_W-1:0]   branch_target_i,
    input  logic [PC_W-1:0]   instr_i,
    input  logic [CTRL_W-1:0] ctrl_id_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   ifid_pc4_o,
    output logic [PC_W-1:0]   ifid_instr_o,
    output logic              ifid_valid_o,
    output logic [CTRL_W-1:0] idex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic              stall_timeout_o,
    output logic              proto_err_o
);

    localparam int               RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PC_W-1:0]  pc_plus4;
    logic             ifid_hold;
    logic             bubble_ev;
    logic             bubble_force;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_next;

    // A branch in the same cycle cancels any hold, so neither counter nor watchdog sees it.
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        pc_plus4     = pc_o + PC_W'(4);
        ifid_hold    = ifid_stall_i & ~branch_taken_i;
        bubble_ev    = nop_ctrl_i & ~branch_taken_i;
        bubble_force = branch_taken_i | nop_ctrl_i | ~ifid_valid_o;
        run_next     = '0;
        if (ifid_hold)
            run_next = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o            <= RESET_PC;
            ifid_pc4_o      <= '0;
            ifid_instr_o    <= '0;
            ifid_valid_o    <= 1'b0;
            idex_ctrl_o     <= '0;
            stall_cnt_o     <= '0;
            bubble_cnt_o    <= '0;
            stall_timeout_o <= 1'b0;
            run_q           <= '0;
        end else begin
            if (branch_taken_i)
                pc_o <= branch_target_i;
            else if (!pc_stall_i)
                pc_o <= pc_plus4;

            if (branch_taken_i) begin
                ifid_pc4_o   <= '0;
                ifid_instr_o <= '0;
                ifid_valid_o <= 1'b0;
            end else if (!ifid_stall_i) begin
                ifid_pc4_o   <= pc_plus4;
                ifid_instr_o <= instr_i;
                ifid_valid_o <= 1'b1;
            end

            idex_ctrl_o <= bubble_force ? '0 : ctrl_id_i;

            if (ifid_hold && stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (bubble_ev && bubble_cnt_o != CNT_MAX)
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);

            run_q <= run_next;
            if (run_next == RUN_MAX)
                stall_timeout_o <= 1'b1;
        end
    end

`ifdef FETCH_STALL_CHECK_EN
    // The three hazard controls come from one load-use detector and must agree.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            proto_err_o <= 1'b0;
        else if ((pc_stall_i != ifid_stall_i) || (ifid_stall_i != nop_ctrl_i))
            proto_err_o <= 1'b1;
    end
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stall_pipe.sv
// Scoreboard bench for fetch_stall_pipe: a driver updates a behavioural model and queues
// the expected post-edge outputs; a monitor pops and compares after every rising edge.
module tb_fetch_stall_pipe;

    localparam int PC_W      = 32;
    localparam int CTRL_W    = 10;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              pc_stall_i = 1'b0, ifid_stall_i = 1'b0, nop_ctrl_i = 1'b0;
    logic              branch_taken_i = 1'b0;
    logic [PC_W-1:0]   branch_target_i = '0, instr_i = '0;
    logic [CTRL_W-1:0] ctrl_id_i = '0;
    logic [PC_W-1:0]   pc_o, ifid_pc4_o, ifid_instr_o;
    logic              ifid_valid_o, stall_timeout_o, proto_err_o;
    logic [CTRL_W-1:0] idex_ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;

    fetch_stall_pipe #(
        .PC_W(PC_W), .RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pc_stall_i(pc_stall_i), .ifid_stall_i(ifid_stall_i), .nop_ctrl_i(nop_ctrl_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .instr_i(instr_i), .ctrl_id_i(ctrl_id_i),
        .pc_o(pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .idex_ctrl_o(idex_ctrl_o),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
        .stall_timeout_o(stall_timeout_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint pc, pc4, instr, ctrl, sc, bc;
        bit     valid, timeout, perr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cycle = 0;

    // Behavioural model state: plain integers, counters as unbounded ints clamped on compare.
    longint m_pc = 0, m_pc4 = 0, m_instr = 0, m_ctrl = 0;
    bit     m_valid = 0, m_timeout = 0, m_perr = 0;
    int     m_stalls = 0, m_bubbles = 0, m_run = 0;
    localparam longint PC_MOD  = 64'd1 << PC_W;
    localparam int     CNT_TOP = (1 << CNT_W) - 1;

    function automatic logic [31:0] instr_at(input longint a);
        case (a)
            0:       return 32'h8C01_0000;
            4:       return 32'h0022_1820;
            8:       return 32'h0000_0000;
            default: return 32'(a * 64'h9E37_79B1) ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs at negedge, advance the model, queue the expectation.
    task automatic step(input bit rst, input bit pcs, input bit ifs, input bit nop,
                        input bit br, input longint tgt);
        longint ctrl;
        longint fetched;
        bit     hold;
        exp_t   e;
        @(negedge clk_i);
        ctrl            = longint'($urandom_range(1023));
        fetched         = longint'(instr_at(m_pc));
        rst_i           = rst;
        pc_stall_i      = pcs;
        ifid_stall_i    = ifs;
        nop_ctrl_i      = nop;
        branch_taken_i  = br;
        branch_target_i = PC_W'(tgt);
        ctrl_id_i       = CTRL_W'(ctrl);
        instr_i         = PC_W'(fetched);
        if (rst) begin
            m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_ctrl = 0;
            m_stalls = 0; m_bubbles = 0; m_run = 0; m_timeout = 0; m_perr = 0;
        end else begin
            hold    = ifs && !br;
            m_ctrl  = (br || nop || !m_valid) ? 0 : ctrl;
            if (hold) m_stalls++;
            if (nop && !br) m_bubbles++;
            m_run   = hold ? m_run + 1 : 0;
            if (m_run >= MAX_STALL) m_timeout = 1;
`ifdef FETCH_STALL_CHECK_EN
            if (!(pcs == ifs && ifs == nop)) m_perr = 1;
`endif
            if (br) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!ifs) begin
                m_instr = fetched; m_pc4 = (m_pc + 4) % PC_MOD; m_valid = 1;
            end
            if (br) m_pc = tgt % PC_MOD;
            else if (!pcs) m_pc = (m_pc + 4) % PC_MOD;
        end
        e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid; e.ctrl = m_ctrl;
        e.sc = (m_stalls > CNT_TOP) ? CNT_TOP : m_stalls;
        e.bc = (m_bubbles > CNT_TOP) ? CNT_TOP : m_bubbles;
        e.timeout = m_timeout; e.perr = m_perr;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation one time unit after the edge it describes.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",         longint'(pc_o),            e.pc);
                check("ifid_pc4",   longint'(ifid_pc4_o),      e.pc4);
                check("ifid_instr", longint'(ifid_instr_o),    e.instr);
                check("ifid_valid", longint'(ifid_valid_o),    longint'(e.valid));
                check("idex_ctrl",  longint'(idex_ctrl_o),     e.ctrl);
                check("stall_cnt",  longint'(stall_cnt_o),     e.sc);
                check("bubble_cnt", longint'(bubble_cnt_o),    e.bc);
                check("timeout",    longint'(stall_timeout_o), longint'(e.timeout));
                check("proto_err",  longint'(proto_err_o),     longint'(e.perr));
            end
        end
    end

    initial begin
        bit h, pcs, ifs, nop, br;
        longint tgt;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Free-run through the three-instruction program, then a one-cycle load-use stall.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Branch collides with a PC stall: redirect wins, nothing counted.
        step(0, 1, 1, 1, 1, 64'h40);
        step(0, 0, 0, 0, 0, 0);
        // Four-cycle stall trips the watchdog, which stays set after release.
        repeat (4) step(0, 1, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // PC wrap from the top of the address space.
        step(0, 0, 0, 0, 1, 64'hFFFF_FFFC);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // Reset in the middle of a stall.
        repeat (2) step(0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // Disagreeing stall controls (checker build flags it; default build must not).
        step(0, 1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Randomised traffic: hazard bursts, branches, rare disagreement and resets.
        h = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 30) h = ~h;
            pcs = h; ifs = h; nop = h;
            if ($urandom_range(99) < 4) begin
                pcs = 1'($urandom); ifs = 1'($urandom); nop = 1'($urandom);
            end
            br  = ($urandom_range(99) < 8);
            tgt = ($urandom_range(3) == 0) ? 64'hFFFF_FFF8 : longint'($urandom & 32'hFFFF_FFFC);
            step(($urandom_range(199) == 0), pcs, ifs, nop, br, tgt);
        end
        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
